// File: rtl/x86_pkg.sv
// Shared encodings for the x86 instruction encoder: opcodes, ModR/M field codes, FSM states.
// The PREFIX state exists only when X86_ENC_OPSIZE_EN is defined.
package x86_pkg;

    typedef enum logic [1:0] {
        OP_ADD_RM_R   = 2'd0,
        OP_ADD_R_RM   = 2'd1,
        OP_MOV_R_RM   = 2'd2,
        OP_ADD_RM8_R8 = 2'd3
    } op_e;

    localparam logic [7:0] OPC_ADD_RM8_R8 = 8'h00;
    localparam logic [7:0] OPC_ADD_RM_R   = 8'h01;
    localparam logic [7:0] OPC_ADD_R_RM   = 8'h03;
    localparam logic [7:0] OPC_MOV_R_RM   = 8'h8B;
    localparam logic [7:0] PFX_OPSIZE     = 8'h66;

    localparam logic [1:0] MOD_IND = 2'b00;
    localparam logic [1:0] MOD_D8  = 2'b01;
    localparam logic [1:0] MOD_D32 = 2'b10;
    localparam logic [1:0] MOD_REG = 2'b11;

    localparam logic [2:0] RM_SIB  = 3'b100;
    localparam logic [2:0] RM_DISP = 3'b101;

    localparam logic [2:0] EAX = 3'd0;
    localparam logic [2:0] ECX = 3'd1;
    localparam logic [2:0] EDX = 3'd2;
    localparam logic [2:0] EBX = 3'd3;
    localparam logic [2:0] ESP = 3'd4;
    localparam logic [2:0] EBP = 3'd5;
    localparam logic [2:0] ESI = 3'd6;
    localparam logic [2:0] EDI = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef X86_ENC_OPSIZE_EN
        ST_PREFIX,
`endif
        ST_OPCODE,
        ST_MODRM,
        ST_SIB,
        ST_DISP
    } enc_state_e;

    function automatic logic [7:0] opcode_byte(input op_e op);
        case (op)
            OP_ADD_RM_R:   opcode_byte = OPC_ADD_RM_R;
            OP_ADD_R_RM:   opcode_byte = OPC_ADD_R_RM;
            OP_MOV_R_RM:   opcode_byte = OPC_MOV_R_RM;
            default:       opcode_byte = OPC_ADD_RM8_R8;
        endcase
    endfunction

endpackage

// File: rtl/x86_enc_len.sv
// Combinational length decode from ModR/M mod/rm and SIB base: SIB presence,
// displacement byte count and instruction length excluding any prefix.
module x86_enc_len
    import x86_pkg::*;
(
    input  logic [1:0] mod,
    input  logic [2:0] rm,
    input  logic [2:0] base,
    output logic       has_sib,
    output logic [2:0] disp_cnt,
    output logic [3:0] len
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        has_sib  = (mod != MOD_REG) && (rm == RM_SIB);
        disp_cnt = 3'd0;
        case (mod)
            MOD_IND: if ((rm == RM_DISP) || (has_sib && (base == RM_DISP))) disp_cnt = 3'd4;
            MOD_D8:  disp_cnt = 3'd1;
            MOD_D32: disp_cnt = 3'd4;
            default: disp_cnt = 3'd0;
        endcase
        len = 4'd2 + {3'b000, has_sib} + {1'b0, disp_cnt};
    end

endmodule

// File: rtl/x86_encoder.sv
// Serialises one latched x86 instruction descriptor into machine-code bytes with a
// valid/ready byte handshake. Define X86_ENC_OPSIZE_EN to add i_opsize16 and the 0x66 prefix.
module x86_encoder
    import x86_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [1:0]  i_mod,
    input  logic [2:0]  i_reg,
    input  logic [2:0]  i_rm,
    input  logic [1:0]  i_scale,
    input  logic [2:0]  i_index,
    input  logic [2:0]  i_base,
    input  logic [31:0] i_disp,
`ifdef X86_ENC_OPSIZE_EN
    input  logic        i_opsize16,
`endif
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_last,
    output logic [3:0]  o_instr_len
);

    enc_state_e state, next_state;

    op_e         op_q;
    logic [7:0]  modrm_q;
    logic [7:0]  sib_q;
    logic [31:0] disp_q;
    logic        has_sib_q;
    logic        has_disp_q;
    logic [1:0]  disp_last_q;
    logic [1:0]  lane_q;

    logic        has_sib_w;
    logic [2:0]  disp_cnt_w;
    logic [3:0]  len_w;
    logic        pfx_w;
    logic        accept;
    logic        advance;

`ifdef X86_ENC_OPSIZE_EN
    assign pfx_w = i_opsize16;
`else
    assign pfx_w = 1'b0;
`endif

    x86_enc_len u_len (
        .mod      (i_mod),
        .rm       (i_rm),
        .base     (i_base),
        .has_sib  (has_sib_w),
        .disp_cnt (disp_cnt_w),
        .len      (len_w)
    );

    assign o_ready      = (state == ST_IDLE);
    assign o_byte_valid = !o_ready;
    assign accept       = i_valid && o_ready;
    assign advance      = o_byte_valid && i_byte_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_byte     = 8'h00;
        o_last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = pfx_w ? enc_state_e'(ST_OPCODE - 3'd1) : ST_OPCODE;
            end
`ifdef X86_ENC_OPSIZE_EN
            ST_PREFIX: begin
                o_byte = PFX_OPSIZE;
                if (advance) next_state = ST_OPCODE;
            end
`endif
            ST_OPCODE: begin
                o_byte = opcode_byte(op_q);
                if (advance) next_state = ST_MODRM;
            end
            ST_MODRM: begin
                o_byte = modrm_q;
                o_last = !has_sib_q && !has_disp_q;
                if (advance) next_state = has_sib_q ? ST_SIB : (has_disp_q ? ST_DISP : ST_IDLE);
            end
            ST_SIB: begin
                o_byte = sib_q;
                o_last = !has_disp_q;
                if (advance) next_state = has_disp_q ? ST_DISP : ST_IDLE;
            end
            ST_DISP: begin
                // Little-endian: lane 0 carries disp[7:0].
                o_byte = disp_q[{lane_q, 3'b000} +: 8];
                o_last = (lane_q == disp_last_q);
                if (advance && o_last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Descriptor is captured only on accept, so input changes mid-instruction are ignored.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_q        <= OP_ADD_RM_R;
            modrm_q     <= 8'h00;
            sib_q       <= 8'h00;
            disp_q      <= 32'h0;
            has_sib_q   <= 1'b0;
            has_disp_q  <= 1'b0;
            disp_last_q <= 2'd0;
            lane_q      <= 2'd0;
            o_instr_len <= 4'd0;
        end else if (accept) begin
            op_q        <= op_e'(i_op);
            modrm_q     <= {i_mod, i_reg, i_rm};
            sib_q       <= {i_scale, i_index, i_base};
            disp_q      <= i_disp;
            has_sib_q   <= has_sib_w;
            has_disp_q  <= (disp_cnt_w != 3'd0);
            disp_last_q <= (disp_cnt_w == 3'd1) ? 2'd0 : 2'd3;
            lane_q      <= 2'd0;
            o_instr_len <= len_w + {3'b000, pfx_w};
        end else if ((state == ST_DISP) && advance) begin
            lane_q <= lane_q + 2'd1;
        end
    end

endmodule

// File: tb/tb_x86_encoder.sv
// Directed table-driven bench for x86_encoder plus backpressure, reset-abort and
// (with X86_ENC_OPSIZE_EN) operand-size prefix sequences.
module tb_x86_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_op = '0;
    logic [1:0]  i_mod = '0;
    logic [2:0]  i_reg = '0;
    logic [2:0]  i_rm = '0;
    logic [1:0]  i_scale = '0;
    logic [2:0]  i_index = '0;
    logic [2:0]  i_base = '0;
    logic [31:0] i_disp = '0;
    logic        i_opsize16 = 1'b0;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        i_byte_ready = 1'b1;
    logic        o_last;
    logic [3:0]  o_instr_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    x86_encoder dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op         (i_op),
        .i_mod        (i_mod),
        .i_reg        (i_reg),
        .i_rm         (i_rm),
        .i_scale      (i_scale),
        .i_index      (i_index),
        .i_base       (i_base),
        .i_disp       (i_disp),
`ifdef X86_ENC_OPSIZE_EN
        .i_opsize16   (i_opsize16),
`endif
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_last       (o_last),
        .o_instr_len  (o_instr_len)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [1:0]  md;
        logic [2:0]  rg;
        logic [2:0]  rm;
        logic [1:0]  sc;
        logic [2:0]  ix;
        logic [2:0]  bs;
        logic [31:0] disp;
        logic        pfx;
        int          len;
        logic [0:7][7:0] eb;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(string name, logic [1:0] op, logic [1:0] md, logic [2:0] rg,
                                logic [2:0] rm, logic [1:0] sc, logic [2:0] ix, logic [2:0] bs,
                                logic [31:0] disp, int len, logic [63:0] eb);
        vec_t v;
        v.name = name; v.op = op; v.md = md; v.rg = rg; v.rm = rm;
        v.sc = sc; v.ix = ix; v.bs = bs; v.disp = disp; v.pfx = 1'b0;
        v.len = len; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for o_ready, presents the descriptor for one edge, then scrambles the inputs.
    task automatic drive(input vec_t v);
        int w = 0;
        while (!o_ready && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) check({v.name, " ready timeout"}, 32'd0, 32'd1);
        i_op = v.op; i_mod = v.md; i_reg = v.rg; i_rm = v.rm;
        i_scale = v.sc; i_index = v.ix; i_base = v.bs; i_disp = v.disp;
        i_opsize16 = v.pfx;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_op = 2'($urandom); i_mod = 2'($urandom); i_reg = 3'($urandom); i_rm = 3'($urandom);
        i_base = 3'($urandom); i_disp = $urandom; i_opsize16 = 1'($urandom);
        check({v.name, " len"}, 32'(o_instr_len), 32'(v.len));
    endtask

    task automatic collect(input vec_t v, input bit first_now);
        for (int k = 0; k < v.len; k++) begin
            int w = 0;
            if (!(first_now && k == 0)) @(negedge clk);
            while (!o_byte_valid && w < 16) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("%s byte%0d", v.name, k), 32'(o_byte), 32'(v.eb[k]));
            check($sformatf("%s last%0d", v.name, k), 32'(o_last), 32'(k == v.len - 1));
        end
        @(negedge clk);
        check({v.name, " valid after"}, 32'(o_byte_valid), 32'd0);
        check({v.name, " ready after"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   found;

        vecs[0] = mk("add_rr",    2'd0, 2'b11, 3'd0, 3'd3, 2'd0, 3'd0, 3'd0, 32'h0,        2, 64'h01C3_0000_0000_0000);
        vecs[1] = mk("mov_sib8",  2'd2, 2'b01, 3'd1, 3'd4, 2'd2, 3'd2, 3'd3, 32'h10,       4, 64'h8B4C_9310_0000_0000);
        vecs[2] = mk("add_abs32", 2'd0, 2'b00, 3'd2, 3'd5, 2'd0, 3'd0, 3'd0, 32'h12345678, 6, 64'h0115_7856_3412_0000);
        vecs[3] = mk("add_sibb5", 2'd1, 2'b00, 3'd0, 3'd4, 2'd0, 3'd1, 3'd5, 32'hAABBCCDD, 7, 64'h0304_0DDD_CCBB_AA00);
        vecs[4] = mk("add8_d32",  2'd3, 2'b10, 3'd3, 3'd6, 2'd0, 3'd0, 3'd0, 32'h00000080, 6, 64'h009E_8000_0000_0000);
        vecs[5] = mk("mov_ind",   2'd2, 2'b00, 3'd7, 3'd0, 2'd0, 3'd0, 3'd0, 32'hFFFFFFFF, 2, 64'h8B38_0000_0000_0000);
        vecs[6] = mk("add_sib32", 2'd0, 2'b10, 3'd5, 3'd4, 2'd3, 3'd4, 3'd5, 32'h01020304, 7, 64'h01AC_E504_0302_0100);
        vecs[7] = mk("add_reg4",  2'd1, 2'b11, 3'd6, 3'd4, 2'd3, 3'd7, 3'd5, 32'hDEADBEEF, 2, 64'h03F4_0000_0000_0000);
        vecs[8] = mk("add_sib0",  2'd0, 2'b00, 3'd1, 3'd4, 2'd1, 3'd3, 3'd0, 32'h55555555, 3, 64'h010C_5800_0000_0000);

        repeat (3) @(negedge clk);
        check("rst byte_valid", 32'(o_byte_valid), 32'd0);
        check("rst byte", 32'(o_byte), 32'd0);
        check("rst last", 32'(o_last), 32'd0);
        check("rst len", 32'(o_instr_len), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after rst", 32'(o_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i]);
            collect(vecs[i], 1'b0);
        end

        // Backpressure on the first byte, with a stray i_valid pulse that must be ignored.
        i_byte_ready = 1'b0;
        drive(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp hold byte%0d", i), 32'(o_byte), 32'h01);
            check($sformatf("bp hold valid%0d", i), 32'(o_byte_valid), 32'd1);
            check($sformatf("bp hold last%0d", i), 32'(o_last), 32'd0);
            if (i == 1) begin
                i_op = 2'd2; i_mod = 2'b10; i_rm = 3'd5; i_valid = 1'b1;
            end else if (i == 2) begin
                i_valid = 1'b0;
            end
        end
        i_byte_ready = 1'b1;
        collect(vecs[0], 1'b1);
        check("bp len kept", 32'(o_instr_len), 32'd2);

        // Reset asserted while the second displacement byte is presented.
        drive(vecs[2]);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (o_byte_valid && o_byte == 8'h56) found = 1'b1;
        end
        check("rst mid reached disp1", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst mid valid", 32'(o_byte_valid), 32'd0);
        check("rst mid len", 32'(o_instr_len), 32'd0);
        check("rst mid last", 32'(o_last), 32'd0);
        repeat (2) @(negedge clk);
        check("rst hold valid", 32'(o_byte_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(vecs[0]);
        collect(vecs[0], 1'b0);

`ifdef X86_ENC_OPSIZE_EN
        v = vecs[0];
        v.name = "opsize";
        v.pfx = 1'b1;
        v.len = 3;
        v.eb = 64'h6601_C300_0000_0000;
        drive(v);
        collect(v, 1'b0);
`else
        v = vecs[0];
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
